// File: rtl/vga_layer_mixer_pkg.sv
// Shared display constants and types for the VGA layer mixer.
//   - 640x480 timing constants (used as parameter defaults)
//   - colour / coordinate widths
//   - vid_ctrl_t: the de/h_sync/v_sync bundle that travels alongside pixels
package vga_layer_mixer_pkg;

  localparam int VGA_H_DISP = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_H_TOTAL = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_DISP = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_V_TOTAL = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W           = 10;
  localparam int H_DISP_LEN      = 10;
  localparam int COLOR_RGB_DEPTH = 12;

  typedef logic [COLOR_RGB_DEPTH-1:0] rgb_t;

  typedef struct packed {
    logic de;
    logic h_sync;
    logic v_sync;
  } vid_ctrl_t;

  // Blanking state: no data, both syncs deasserted (they are active-low).
  localparam vid_ctrl_t CTRL_IDLE = '{de: 1'b0, h_sync: 1'b1, v_sync: 1'b1};

endpackage

// File: rtl/vga_layer_mixer_timing.sv
// vga_timing_gen: h/v scan counters plus raw sync, data-enable and
// per-pixel request generation.
// Ports:
//   clk_vga      pixel clock
//   rst_n        synchronous active-low reset
//   req_x_addr   requested column (0 outside the active area)
//   req_y_addr   requested row    (0 outside the active area)
//   req_valid    request lies in the active area
//   de_raw       undelayed data enable (same as req_valid)
//   h_sync_raw   undelayed horizontal sync, active-low
//   v_sync_raw   undelayed vertical sync, active-low
//   frame_tick   high while the counters sit at the first blanking line, column 0
module vga_timing_gen
  import vga_layer_mixer_pkg::*;
#(
  parameter int H_DISP = VGA_H_DISP,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_DISP = VGA_V_DISP,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic                  clk_vga,
  input  logic                  rst_n,
  output logic [H_DISP_LEN-1:0] req_x_addr,
  output logic [H_DISP_LEN-1:0] req_y_addr,
  output logic                  req_valid,
  output logic                  de_raw,
  output logic                  h_sync_raw,
  output logic                  v_sync_raw,
  output logic                  frame_tick
);

  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_DISP + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_DISP + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign req_valid  = active;
  assign req_x_addr = active ? H_DISP_LEN'(h_cnt) : '0;
  assign req_y_addr = active ? H_DISP_LEN'(v_cnt) : '0;
  assign de_raw     = active;
  assign h_sync_raw = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign v_sync_raw = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign frame_tick = (v_cnt == V_ACT) && (h_cnt == '0);

endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: VGA scan master and layer compositor.
// Broadcasts pixel requests to all object layers, delays the raw
// de/sync by the layer latency, picks the highest-priority opaque layer
// and registers colour, de and syncs together onto the pins.
// Ports:
//   clk_vga        pixel clock
//   rst_n          synchronous active-low reset
//   layer_alpha_i  opaque flag per layer (index 0 = highest priority)
//   layer_rgb_i    packed layer colours, layer k at [k*D +: D]
//   req_x_addr_o   requested column
//   req_y_addr_o   requested row
//   req_valid_o    request lies in the active area
//   v_sync_o       vertical sync, active-low, aligned with vga_rgb_o
//   h_sync_o       horizontal sync, active-low, aligned with vga_rgb_o
//   de_o           data enable, aligned with vga_rgb_o
//   frame_start_o  one-cycle pulse at the start of vertical blanking
//   vga_rgb_o      composited pixel colour
module vga_layer_mixer
  import vga_layer_mixer_pkg::*;
#(
  parameter int   LAYER_NUM = 4,
  parameter int   LAYER_LAT = 2,
  parameter rgb_t BG_RGB    = '0,
  parameter int   H_DISP    = VGA_H_DISP,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_DISP    = VGA_V_DISP,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP
) (
  input  logic                                 clk_vga,
  input  logic                                 rst_n,
  input  logic [LAYER_NUM-1:0]                 layer_alpha_i,
  input  logic [LAYER_NUM*COLOR_RGB_DEPTH-1:0] layer_rgb_i,
  output logic [H_DISP_LEN-1:0]                req_x_addr_o,
  output logic [H_DISP_LEN-1:0]                req_y_addr_o,
  output logic                                 req_valid_o,
  output logic                                 v_sync_o,
  output logic                                 h_sync_o,
  output logic                                 de_o,
  output logic                                 frame_start_o,
  output logic [COLOR_RGB_DEPTH-1:0]           vga_rgb_o
);

  // Lowest-index opaque layer wins; walking from the top index down lets
  // each higher-priority hit overwrite the previous one. Outside the
  // active area the layer inputs are ignored and black is forced.
  function automatic rgb_t resolve_pixel(
    input logic [LAYER_NUM-1:0]                 alpha,
    input logic [LAYER_NUM*COLOR_RGB_DEPTH-1:0] colours,
    input logic                                 de
  );
    rgb_t pix;
    pix = BG_RGB;
    for (int k = LAYER_NUM - 1; k >= 0; k--) begin
      if (alpha[k]) pix = colours[k*COLOR_RGB_DEPTH +: COLOR_RGB_DEPTH];
    end
    if (!de) pix = '0;
    return pix;
  endfunction

  vid_ctrl_t ctrl_p0;
  vid_ctrl_t ctrl_dly_p1 [LAYER_LAT];
  vid_ctrl_t ctrl_aligned;
  logic      frame_tick_p0;
  rgb_t      rgb_resolved;

  // ---- stage p0: scan counters and raw request/sync generation ----
  vga_timing_gen #(
    .H_DISP (H_DISP),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_DISP (V_DISP),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk_vga    (clk_vga),
    .rst_n      (rst_n),
    .req_x_addr (req_x_addr_o),
    .req_y_addr (req_y_addr_o),
    .req_valid  (req_valid_o),
    .de_raw     (ctrl_p0.de),
    .h_sync_raw (ctrl_p0.h_sync),
    .v_sync_raw (ctrl_p0.v_sync),
    .frame_tick (frame_tick_p0)
  );

  // ---- stage p1..pLAT: control delay line matching the layer latency ----
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      for (int i = 0; i < LAYER_LAT; i++) ctrl_dly_p1[i] <= CTRL_IDLE;
    end else begin
      ctrl_dly_p1[0] <= ctrl_p0;
      for (int i = 1; i < LAYER_LAT; i++) ctrl_dly_p1[i] <= ctrl_dly_p1[i-1];
    end
  end

  assign ctrl_aligned = ctrl_dly_p1[LAYER_LAT-1];
  assign rgb_resolved = resolve_pixel(layer_alpha_i, layer_rgb_i, ctrl_aligned.de);

  // ---- output register: colour, de and syncs leave together ----
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      vga_rgb_o     <= '0;
      de_o          <= 1'b0;
      h_sync_o      <= 1'b1;
      v_sync_o      <= 1'b1;
      frame_start_o <= 1'b0;
    end else begin
      vga_rgb_o     <= rgb_resolved;
      de_o          <= ctrl_aligned.de;
      h_sync_o      <= ctrl_aligned.h_sync;
      v_sync_o      <= ctrl_aligned.v_sync;
      frame_start_o <= frame_tick_p0;
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Bench for vga_layer_mixer. Horizontal timing is the full 800-clock line;
// the vertical geometry is shortened to 28 lines so that several whole
// frames fit in a short run. A layer model answers each request two
// cycles later; a cycle-index model predicts every pin.
module tb_vga_layer_mixer;

  localparam int HD = 640, HFP = 16, HS = 96, HBP = 48, HT = HD + HFP + HS + HBP;
  localparam int VD = 20,  VFP = 2,  VS = 2,  VBP = 4,  VT = VD + VFP + VS + VBP;
  localparam int FR  = HT * VT;
  localparam int LAT = 2;
  localparam logic [11:0] BG = 12'h123;

  logic        clk_vga = 1'b0;
  logic        rst_n   = 1'b0;
  logic [3:0]  layer_alpha_i;
  logic [47:0] layer_rgb_i;
  logic [9:0]  req_x_addr_o, req_y_addr_o;
  logic        req_valid_o, v_sync_o, h_sync_o, de_o, frame_start_o;
  logic [11:0] vga_rgb_o;

  int checks = 0, errors = 0;
  int cyc = 0, seg = 0;
  bit started = 0, rs_low = 0;
  logic [3:0]  a_hist [8];
  logic [47:0] c_hist [8];
  int qx [8], qy [8];
  bit qv [8];
  int fs_cnt = 0, hs_lo = 0, vs_lo = 0, de_hi = 0;

  vga_layer_mixer #(
    .LAYER_NUM(4), .LAYER_LAT(LAT), .BG_RGB(BG),
    .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk_vga       (clk_vga),
    .rst_n         (rst_n),
    .layer_alpha_i (layer_alpha_i),
    .layer_rgb_i   (layer_rgb_i),
    .req_x_addr_o  (req_x_addr_o),
    .req_y_addr_o  (req_y_addr_o),
    .req_valid_o   (req_valid_o),
    .v_sync_o      (v_sync_o),
    .h_sync_o      (h_sync_o),
    .de_o          (de_o),
    .frame_start_o (frame_start_o),
    .vga_rgb_o     (vga_rgb_o)
  );

  always #20 clk_vga = ~clk_vga;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s seg=%0d cyc=%0d got=%0h want=%0h", name, seg, cyc, act, exp);
    end
  endtask

  // Scan position of the counters in cycle c after reset release.
  function automatic int hpos(input int c); return c % HT; endfunction
  function automatic int vpos(input int c); return (c / HT) % VT; endfunction
  function automatic bit act_at(input int c); return (hpos(c) < HD) && (vpos(c) < VD); endfunction

  function automatic int pick(input logic [3:0] a, input logic [47:0] c);
    for (int k = 0; k < 4; k++) if (a[k]) return int'(c[k*12 +: 12]);
    return int'(BG);
  endfunction

  // Layer model: answers the request seen LAT cycles ago. During blanking
  // every layer claims opaque white, which the mixer must ignore.
  task automatic drive_layers(input int c);
    logic [3:0]  a;
    logic [47:0] col;
    int x, y;
    bit v;
    a = 4'b1111;
    col = {4{12'hFFF}};
    if (c >= LAT) begin
      x = qx[(c - LAT) % 8];
      y = qy[(c - LAT) % 8];
      v = qv[(c - LAT) % 8];
      if (v) begin
        case (y % 4)
          0: begin a = 4'b0001; col = {12'hABC, 12'hABC, 12'hABC, 12'(x)}; end
          1: begin a = 4'b1010; col = {12'h00F, 12'h777, 12'h0F0, 12'hF00}; end
          2: begin a = 4'b1011; col = {12'h00F, 12'h777, 12'h0F0, 12'hF00}; end
          default: begin a = 4'b0000; col = {4{12'hFFF}}; end
        endcase
      end
    end
    layer_alpha_i = a;
    layer_rgb_i   = col;
    a_hist[c % 8] = a;
    c_hist[c % 8] = col;
  endtask

  task automatic step();
    @(posedge clk_vga);
    #1;
    rs_low = !rst_n;
    if (!rst_n) cyc = 0;
    else cyc++;
    started = 1;
    qx[cyc % 8] = int'(req_x_addr_o);
    qy[cyc % 8] = int'(req_y_addr_o);
    qv[cyc % 8] = req_valid_o;
    drive_layers(cyc);
  endtask

  // Compare process: every cycle, predict all outputs from the cycle index.
  always @(negedge clk_vga) begin
    int m, p, e_de, e_hs, e_vs, e_rgb, e_fs;
    if (started) begin
      m = cyc;
      chk("req_valid", int'(req_valid_o), int'(act_at(m)));
      chk("req_x", int'(req_x_addr_o), act_at(m) ? hpos(m) : 0);
      chk("req_y", int'(req_y_addr_o), act_at(m) ? vpos(m) : 0);
      if (m >= LAT + 1) begin
        p = m - LAT - 1;
        e_de  = int'(act_at(p));
        e_hs  = (hpos(p) >= HD + HFP && hpos(p) < HD + HFP + HS) ? 0 : 1;
        e_vs  = (vpos(p) >= VD + VFP && vpos(p) < VD + VFP + VS) ? 0 : 1;
        e_rgb = (e_de != 0) ? pick(a_hist[(m - 1) % 8], c_hist[(m - 1) % 8]) : 0;
      end else begin
        e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 0;
      end
      e_fs = (m >= 1 && hpos(m - 1) == 0 && vpos(m - 1) == VD) ? 1 : 0;
      chk("de", int'(de_o), e_de);
      chk("h_sync", int'(h_sync_o), e_hs);
      chk("v_sync", int'(v_sync_o), e_vs);
      chk("rgb", int'(vga_rgb_o), e_rgb);
      chk("frame_start", int'(frame_start_o), e_fs);

      if (rs_low) begin
        chk("rst_rgb", int'(vga_rgb_o), 0);
        chk("rst_de", int'(de_o), 0);
        chk("rst_hs", int'(h_sync_o), 1);
        chk("rst_vs", int'(v_sync_o), 1);
        chk("rst_fs", int'(frame_start_o), 0);
      end

      if (seg == 0 && !rs_low) begin
        if (m == 2) chk("pre_first_de", int'(de_o), 0);
        if (m == 3) begin
          chk("first_de", int'(de_o), 1);
          chk("first_rgb", int'(vga_rgb_o), 0);
        end
        if (m == 8) chk("x5_rgb", int'(vga_rgb_o), 5);
        if (m == HT + 13) chk("prio_l1_over_l3", int'(vga_rgb_o), 12'h0F0);
        if (m == 2 * HT + 13) chk("prio_l0_wins", int'(vga_rgb_o), 12'hF00);
        if (m == 3 * HT + 13) chk("prio_bg", int'(vga_rgb_o), 12'h123);
        if (m == 703) begin
          chk("blank_rgb", int'(vga_rgb_o), 0);
          chk("blank_de", int'(de_o), 0);
        end
        if (m == 658) chk("hs_before", int'(h_sync_o), 1);
        if (m == 659) chk("hs_first_low", int'(h_sync_o), 0);
        if (m == 755) chk("hs_after", int'(h_sync_o), 1);
        if (m == (VD + VFP) * HT + 3) chk("vs_first_low", int'(v_sync_o), 0);
        if (m == VD * HT) chk("fs_before", int'(frame_start_o), 0);
        if (m == VD * HT + 1) chk("fs_pulse", int'(frame_start_o), 1);

        if (m >= 3 && m < 3 + 2 * FR) begin
          hs_lo += int'(!h_sync_o);
          vs_lo += int'(!v_sync_o);
          de_hi += int'(de_o);
        end
        if (m >= 1 && m < 1 + 2 * FR) fs_cnt += int'(frame_start_o);
        if (m == 3 + 2 * FR) begin
          chk("hs_low_total", hs_lo, 2 * VT * HS);
          chk("vs_low_total", vs_lo, 2 * VS * HT);
          chk("de_high_total", de_hi, 2 * VD * HD);
          chk("fs_pulse_total", fs_cnt, 2);
        end
      end

      if (seg == 1 && !rs_low) begin
        if (m == 3) begin
          chk("restart_first_de", int'(de_o), 1);
          chk("restart_first_rgb", int'(vga_rgb_o), 0);
        end
        if (m == VD * HT + 1) chk("restart_fs_pulse", int'(frame_start_o), 1);
      end
    end
  end

  initial begin
    bit found;
    layer_alpha_i = 4'b1111;
    layer_rgb_i   = {4{12'hFFF}};
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b1;

    for (int i = 0; i < 2 * FR + 10; i++) step();

    // Reset pulse in the middle of a frame, at pixel (300, 10).
    found = 0;
    for (int i = 0; i < FR + 10 && !found; i++) begin
      step();
      if (req_valid_o && req_x_addr_o == 10'd300 && req_y_addr_o == 10'd10) found = 1;
    end
    chk("mid_reset_point_found", int'(found), 1);
    seg = 1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("restart_req_x", int'(req_x_addr_o), 0);
    chk("restart_req_y", int'(req_y_addr_o), 0);
    chk("restart_req_valid", int'(req_valid_o), 1);
    for (int i = 0; i < VD * HT + 10; i++) step();

    @(negedge clk_vga);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
